// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Load/store request/response bundle for mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        err;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, wr, size, addr, wdata,
    input  ready, err, rdata, busy
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output ready, err, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-organised RAM responder with wait states, sub-word
//                read-modify-write stores and error responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          LAW       = AW + 2;
  localparam logic [2:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
  localparam logic [1:0]  SZ_WORD   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_BYTE   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERR    = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [1:0]       size_q, size_d;
  logic [LAW-1:0]   addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             illegal_req;
  logic [AW-1:0]    word_idx;
  logic [4:0]       lane_shamt;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shifted;
  logic [31:0]      load_val;
  logic [31:0]      lane_mask;
  logic [31:0]      merged_word;
  logic             mem_we;

  // Legality is judged on the live bus fields, before they are latched.
  always_comb begin
    illegal_req = 1'b0;
    case (bus.size)
      SZ_WORD: illegal_req = (bus.addr[1:0] != 2'b00);
      SZ_HALF: illegal_req = bus.addr[0];
      SZ_BYTE: illegal_req = 1'b0;
      default: illegal_req = 1'b1;
    endcase
    if (bus.addr[31:LAW] != '0) begin
      illegal_req = 1'b1;
    end
  end

  assign word_idx   = addr_q[LAW-1:2];
  assign lane_shamt = {addr_q[1:0], 3'b000};
  assign rd_word    = mem_q[word_idx];
  assign rd_shifted = rd_word >> lane_shamt;

  always_comb begin
    load_val  = rd_word;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      SZ_HALF: begin
        load_val  = {16'h0000, rd_shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shamt;
      end
      SZ_BYTE: begin
        load_val  = {24'h000000, rd_shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shamt;
      end
      default: begin
        load_val  = rd_word;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Sub-word stores keep the untouched lanes of the old word.
  assign merged_word = (rd_word & ~lane_mask) | ((wdata_q << lane_shamt) & lane_mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          size_d  = bus.size;
          addr_d  = bus.addr[LAW-1:0];
          wdata_d = bus.wdata;
          if (illegal_req) begin
            state_d = S_ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ready_d = 1'b1;
        if (wr_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = load_val;
        end
      end
      S_ERR:   state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      if (mem_we) begin
        mem_q[word_idx] <= merged_word;
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard bench for mem_responder at WAIT_CYCLES 1, 3 and 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [2:0]  req_v;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;

  mem_responder_if bus_w1 ();
  mem_responder_if bus_w3 ();
  mem_responder_if bus_w0 ();

  assign bus_w1.req = req_v[0];
  assign bus_w1.wr = wr;
  assign bus_w1.size = size;
  assign bus_w1.addr = addr;
  assign bus_w1.wdata = wdata;
  assign bus_w3.req = req_v[1];
  assign bus_w3.wr = wr;
  assign bus_w3.size = size;
  assign bus_w3.addr = addr;
  assign bus_w3.wdata = wdata;
  assign bus_w0.req = req_v[2];
  assign bus_w0.wr = wr;
  assign bus_w0.size = size;
  assign bus_w0.addr = addr;
  assign bus_w0.wdata = wdata;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut_w1 (.clk(clk), .reset(rst_v[0]), .bus(bus_w1));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut_w3 (.clk(clk), .reset(rst_v[1]), .bus(bus_w3));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .reset(rst_v[2]), .bus(bus_w0));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int neg_cnt = 0;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat(input int id);
    case (id)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic rdy, input logic e, input logic [31:0] rd);
    exp_t x;
    int   have;
    if (e && !rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d err_without_ready at negedge %0d", id, neg_cnt);
    end
    if (rdy) begin
      case (id)
        0:       have = q0.size();
        1:       have = q1.size();
        default: have = q2.size();
      endcase
      n_tests++;
      if (have == 0) begin
        n_fail++;
        $display("FAIL dut%0d unexpected_ready at negedge %0d err=%b rdata=%h", id, neg_cnt, e, rd);
      end else begin
        case (id)
          0:       x = q0.pop_front();
          1:       x = q1.pop_front();
          default: x = q2.pop_front();
        endcase
        if (e !== x.err || rd !== x.rdata || neg_cnt != x.due) begin
          n_fail++;
          $display("FAIL dut%0d response: got err=%b rdata=%h at %0d, want err=%b rdata=%h at %0d",
                   id, e, rd, neg_cnt, x.err, x.rdata, x.due);
        end
      end
    end
  endtask

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    neg_cnt++;
    mon(0, bus_w1.ready, bus_w1.err, bus_w1.rdata);
    mon(1, bus_w3.ready, bus_w3.err, bus_w3.rdata);
    mon(2, bus_w0.ready, bus_w0.err, bus_w0.rdata);
  end

  task automatic push(input int id, input exp_t x);
    case (id)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic issue(input int id, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
    exp_t x;
    @(negedge clk);
    #1;
    wr = w;
    size = s;
    addr = a;
    wdata = d;
    req_v[id] = 1'b1;
    x.err = e_err;
    x.rdata = e_rd;
    x.due = neg_cnt + (e_err ? 1 : lat(id) + 2);
    push(id, x);
    @(posedge clk);
    #1;
    req_v[id] = 1'b0;
    repeat (lat(id) + 4) @(posedge clk);
  endtask

  logic [8:1] busy_pat;

  initial begin
    exp_t x;
    int   n0;
    rst_v = 3'b111;
    req_v = 3'b000;
    wr = 1'b0;
    size = 2'b00;
    addr = 32'h0;
    wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 3'b000;
    @(negedge clk);
    #1;
    chk("reset_w1", {bus_w1.ready, bus_w1.err, bus_w1.busy, bus_w1.rdata[28:0]}, 32'h0);
    chk("reset_w1_rdata", bus_w1.rdata, 32'h0);
    chk("reset_w3", {29'h0, bus_w3.ready, bus_w3.err, bus_w3.busy}, 32'h0);
    chk("reset_w0", {29'h0, bus_w0.ready, bus_w0.err, bus_w0.busy}, 32'h0);

    // WAIT_CYCLES=1: functional directed vectors
    issue(0, 1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'h0000_0000);
    issue(0, 1'b1, 2'b00, 32'h08,  32'hDEADBEEF, 1'b0, 32'h0000_0000);
    issue(0, 1'b0, 2'b00, 32'h08,  32'h0,        1'b0, 32'hDEADBEEF);
    issue(0, 1'b1, 2'b10, 32'h09,  32'h000000AB, 1'b0, 32'hDEADBEEF);
    issue(0, 1'b0, 2'b00, 32'h08,  32'h0,        1'b0, 32'hDEADABEF);
    issue(0, 1'b0, 2'b10, 32'h0B,  32'h0,        1'b0, 32'h0000_00DE);
    issue(0, 1'b0, 2'b01, 32'h0A,  32'h0,        1'b0, 32'h0000_DEAD);
    issue(0, 1'b1, 2'b00, 32'h04,  32'hCAFEF00D, 1'b0, 32'h0000_DEAD);
    issue(0, 1'b0, 2'b00, 32'h06,  32'h0,        1'b1, 32'h0000_0000);
    issue(0, 1'b1, 2'b01, 32'h03,  32'h00001234, 1'b1, 32'h0000_0000);
    issue(0, 1'b1, 2'b11, 32'h04,  32'hFFFFFFFF, 1'b1, 32'h0000_0000);
    issue(0, 1'b0, 2'b00, 32'h400, 32'h0,        1'b1, 32'h0000_0000);
    issue(0, 1'b0, 2'b00, 32'h04,  32'h0,        1'b0, 32'hCAFEF00D);
    issue(0, 1'b1, 2'b01, 32'h06,  32'h0000BEEF, 1'b0, 32'hCAFEF00D);
    issue(0, 1'b0, 2'b00, 32'h04,  32'h0,        1'b0, 32'hBEEFF00D);
    issue(0, 1'b0, 2'b10, 32'h05,  32'h0,        1'b0, 32'h0000_00F0);
    issue(0, 1'b1, 2'b10, 32'h3FF, 32'h0000005A, 1'b0, 32'h0000_00F0);
    issue(0, 1'b0, 2'b00, 32'h3FC, 32'h0,        1'b0, 32'h5A00_0000);

    // WAIT_CYCLES=3: normal latency, then a store aborted by reset mid-WAIT
    issue(1, 1'b1, 2'b00, 32'h24, 32'h11112222, 1'b0, 32'h0000_0000);
    issue(1, 1'b0, 2'b00, 32'h24, 32'h0,        1'b0, 32'h1111_2222);
    @(negedge clk);
    #1;
    wr = 1'b1;
    size = 2'b00;
    addr = 32'h20;
    wdata = 32'h12345678;
    req_v[1] = 1'b1;
    @(posedge clk);
    #1;
    req_v[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_v[1] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[1] = 1'b0;
    @(negedge clk);
    chk("abort_busy_ready", {30'h0, bus_w3.busy, bus_w3.ready}, 32'h0);
    chk("abort_rdata_cleared", bus_w3.rdata, 32'h0);
    repeat (8) @(posedge clk);
    issue(1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0, 32'h0000_0000);
    issue(1, 1'b0, 2'b00, 32'h24, 32'h0, 1'b0, 32'h0000_0000);

    // WAIT_CYCLES=0: req held high is serviced every third cycle
    busy_pat = 8'b1101_1011;
    @(negedge clk);
    #1;
    wr = 1'b0;
    size = 2'b00;
    addr = 32'h0;
    req_v[2] = 1'b1;
    n0 = neg_cnt;
    for (int k = 0; k < 3; k++) begin
      x.err = 1'b0;
      x.rdata = 32'h0;
      x.due = n0 + 2 + 3 * k;
      push(2, x);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("held_busy_%0d", c), {31'h0, bus_w0.busy}, {31'h0, busy_pat[c]});
      if (c == 6) begin
        @(posedge clk);
        #1;
        req_v[2] = 1'b0;
      end
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_w1", q0.size(), 32'd0);
    chk("pending_w3", q1.size(), 32'd0);
    chk("pending_w0", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
